// File: rtl/w_unload_counter.sv
// rtl/w_unload_counter.sv - splits a W sum back into counter1/counter2 values with start/busy/done handshake
//
// Purpose: counterpart of the counter-pair / W-register block. A W sum captured with start is
//   redistributed into count1/count2 in the same fill order: both counters step together until
//   count2 reaches CAP2, then count1 steps alone. Sums above CAP1+CAP2 raise a sticky err.
//   All state updates happen on the falling clock edge.
//
// Ports:
//   clk      in   1          clock (falling edge active)
//   reset    in   1          asynchronous active-low reset
//   start    in   1          request, sampled only in IDLE
//   w_input  in   W_WIDTH    sum to split, captured with an accepted start
//   count1   out  CNT_WIDTH  counter1 value, held after done
//   count2   out  CNT_WIDTH  counter2 value, held after done
//   busy     out  1          high in LOAD/BOTH/ONE
//   done     out  1          one-cycle pulse in DONE
//   err      out  1          sticky out-of-range flag, cleared by the next accepted start
//
// Configuration macro: W_SAT_CLAMP_EN
//   defined     : out-of-range sums are clamped to CAP1+CAP2 and split normally; err stays 0.
//   not defined : out-of-range sums go through ERR and set err.

module w_unload_counter #(
   parameter int W_WIDTH   = 5,
   parameter int CNT_WIDTH = 4,
   parameter int CAP1      = 9,
   parameter int CAP2      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [W_WIDTH-1:0]   w_input,
   output logic [CNT_WIDTH-1:0] count1,
   output logic [CNT_WIDTH-1:0] count2,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_BOTH = 3'd2,
      S_ONE  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [W_WIDTH-1:0]   MAX_W   = W_WIDTH'(CAP1 + CAP2);
   localparam logic [W_WIDTH-1:0]   REM_ONE = W_WIDTH'(1);
   localparam logic [W_WIDTH-1:0]   REM_TWO = W_WIDTH'(2);
   localparam logic [CNT_WIDTH-1:0] CAP2_C  = CNT_WIDTH'(CAP2);

   state_t               state_q, state_d;
   logic [W_WIDTH-1:0]   rem_q, rem_d;
   logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
   logic [CNT_WIDTH-1:0] cnt2_q, cnt2_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt1_d  = cnt1_q;
      cnt2_d  = cnt2_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               rem_d   = w_input;
               cnt1_d  = '0;
               cnt2_d  = '0;
               err_d   = 1'b0;
            end
         end

         S_LOAD: begin
            if (rem_q > MAX_W) begin
`ifdef W_SAT_CLAMP_EN
               rem_d   = MAX_W;
               state_d = S_BOTH;
`else
               state_d = S_ERR;
`endif
            end else if (rem_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_BOTH;
            end
         end

         S_BOTH: begin
            if (rem_q == '0) begin
               state_d = S_DONE;
            end else if (rem_q >= REM_TWO && cnt2_q < CAP2_C) begin
               cnt1_d  = cnt1_q + 1'b1;
               cnt2_d  = cnt2_q + 1'b1;
               rem_d   = rem_q - REM_TWO;
               state_d = (rem_q == REM_TWO) ? S_DONE : S_BOTH;
            end else begin
               // Falling out of the paired phase still performs one single step on this edge.
               cnt1_d  = cnt1_q + 1'b1;
               rem_d   = rem_q - REM_ONE;
               state_d = (rem_q == REM_ONE) ? S_DONE : S_ONE;
            end
         end

         S_ONE: begin
            if (rem_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt1_d  = cnt1_q + 1'b1;
               rem_d   = rem_q - REM_ONE;
               state_d = (rem_q == REM_ONE) ? S_DONE : S_ONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         S_ERR: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake outputs are registered from the next state so they line up with the state register.
   assign busy_d = (state_d == S_LOAD) || (state_d == S_BOTH) || (state_d == S_ONE);
   assign done_d = (state_d == S_DONE);

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt1_q  <= cnt1_d;
         cnt2_q  <= cnt2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign count1 = cnt1_q;
   assign count2 = cnt2_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_w_unload_counter.sv
// tb/tb_w_unload_counter.sv - scoreboard bench for w_unload_counter

module tb_w_unload_counter;

   localparam int W_WIDTH   = 5;
   localparam int CNT_WIDTH = 4;
   localparam int CAP1      = 9;
   localparam int CAP2      = 4;
   localparam int MAXW      = CAP1 + CAP2;
   localparam int WAIT_MAX  = 20;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [W_WIDTH-1:0]   w_input;
   logic [CNT_WIDTH-1:0] count1;
   logic [CNT_WIDTH-1:0] count2;
   logic                 busy;
   logic                 done;
   logic                 err;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int c1;
      int c2;
      int e;
      int lat;
      int busy_cycles;
   } exp_t;

   exp_t sb[$];

   w_unload_counter #(
      .W_WIDTH  (W_WIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .CAP1     (CAP1),
      .CAP2     (CAP2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .w_input(w_input),
      .count1 (count1),
      .count2 (count2),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input int w);
      exp_t r;
      int ww;
      int both;
      ww = w;
`ifdef W_SAT_CLAMP_EN
      if (ww > MAXW) ww = MAXW;
`endif
      if (ww > MAXW) begin
         r.c1 = 0; r.c2 = 0; r.e = 1; r.lat = 0; r.busy_cycles = 1;
      end else begin
         both = (ww / 2 < CAP2) ? ww / 2 : CAP2;
         r.c1 = ww - both;
         r.c2 = both;
         r.e = 0;
         r.lat = 1 + both + (ww - 2 * both);
         r.busy_cycles = r.lat;
      end
      return r;
   endfunction

   // Drives one request; ign_at > 0 re-asserts start with w=5 at that edge offset.
   task automatic run_op(input string tag, input int w, input int ign_at);
      exp_t e;
      int lat;
      int bcnt;
      sb.push_back(model(w));
      @(posedge clk);
      start = 1'b1;
      w_input = W_WIDTH'(w);
      @(negedge clk);
      @(posedge clk);
      start = 1'b0;
      lat = 0;
      bcnt = (busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= WAIT_MAX; k++) begin
         if (k == ign_at) begin
            start = 1'b1;
            w_input = W_WIDTH'(5);
         end
         @(negedge clk);
         @(posedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (busy === 1'b1) bcnt++;
      end
      e = sb.pop_front();
      check({tag, " latency"}, lat, e.lat);
      check({tag, " busy_cycles"}, bcnt, e.busy_cycles);
      check({tag, " count1"}, int'(count1), e.c1);
      check({tag, " count2"}, int'(count2), e.c2);
      check({tag, " err"}, int'(err), e.e);
      if (e.lat != 0) begin
         @(negedge clk);
         @(posedge clk);
         check({tag, " done_pulse_end"}, int'(done), 0);
         check({tag, " count1_held"}, int'(count1), e.c1);
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      w_input = '0;
      repeat (2) @(posedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(posedge clk);
      check("rst count1", int'(count1), 0);
      check("rst count2", int'(count2), 0);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst err", int'(err), 0);

      run_op("w13", 13, 0);
      run_op("w3", 3, 0);
      run_op("w0", 0, 0);
      run_op("w20", 20, 0);
      run_op("w13_ignore", 13, 4);
      run_op("w2", 2, 0);

      // Mid-operation reset abandons the sequence immediately.
      @(posedge clk);
      start = 1'b1;
      w_input = W_WIDTH'(13);
      @(negedge clk);
      @(posedge clk);
      start = 1'b0;
      repeat (5) begin
         @(negedge clk);
         @(posedge clk);
      end
      check("pre_rst busy", int'(busy), 1);
      reset = 1'b0;
      #1;
      check("midrst count1", int'(count1), 0);
      check("midrst count2", int'(count2), 0);
      check("midrst busy", int'(busy), 0);
      check("midrst done", int'(done), 0);
      repeat (2) @(posedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(posedge clk);
      check("post_rst busy", int'(busy), 0);
      run_op("w1_after_rst", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
